// File: rtl/tdm_demux4_if.sv
// rtl/tdm_demux4_if.sv - beat input and frame output bundle for the 1-to-4 TDM demultiplexer
interface tdm_demux4_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             dvalid;
  logic             sync;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [1:0]       s;
  logic             locked;
  logic             frame_valid;
  logic             sync_err;

  modport master (
    output din, dvalid, sync,
    input  a, b, c, d, s, locked, frame_valid, sync_err
  );

  modport slave (
    input  din, dvalid, sync,
    output a, b, c, d, s, locked, frame_valid, sync_err
  );
endinterface

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 1-to-4 TDM demultiplexer with SYNC-marker framing
// Beats fill shadow slots 0..2; the slot-3 beat publishes a whole frame at once.
module tdm_demux4 #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  tdm_demux4_if.slave   bus
);
  typedef enum logic {S_HUNT, S_LOCKED} state_t;

  state_t           state, state_n;
  logic [1:0]       slot, slot_n;
  logic [WIDTH-1:0] sh0, sh1, sh2;
  logic [WIDTH-1:0] sh0_n, sh1_n, sh2_n;
  logic [WIDTH-1:0] a_r, b_r, c_r, d_r;
  logic [WIDTH-1:0] a_n, b_n, c_n, d_n;
  logic             fv_r, fv_n;
  logic             se_r, se_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_HUNT;
      slot  <= 2'd0;
      sh0   <= '0;
      sh1   <= '0;
      sh2   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      c_r   <= '0;
      d_r   <= '0;
      fv_r  <= 1'b0;
      se_r  <= 1'b0;
    end else begin
      state <= state_n;
      slot  <= slot_n;
      sh0   <= sh0_n;
      sh1   <= sh1_n;
      sh2   <= sh2_n;
      a_r   <= a_n;
      b_r   <= b_n;
      c_r   <= c_n;
      d_r   <= d_n;
      fv_r  <= fv_n;
      se_r  <= se_n;
    end
  end

  always_comb begin
    state_n = state;
    slot_n  = slot;
    sh0_n   = sh0;
    sh1_n   = sh1;
    sh2_n   = sh2;
    a_n     = a_r;
    b_n     = b_r;
    c_n     = c_r;
    d_n     = d_r;
    fv_n    = 1'b0;
    se_n    = 1'b0;

    if (bus.dvalid) begin
      case (state)
        S_HUNT: begin
          if (bus.sync) begin
            sh0_n   = bus.din;
            slot_n  = 2'd1;
            state_n = S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (bus.sync && (slot != 2'd0)) begin
            // Realign: drop the partial frame and restart at slot 0 with this beat.
            se_n   = 1'b1;
            sh0_n  = bus.din;
            slot_n = 2'd1;
          end else begin
            slot_n = slot + 2'd1;
            case (slot)
              2'd0: sh0_n = bus.din;
              2'd1: sh1_n = bus.din;
              2'd2: sh2_n = bus.din;
              default: begin
                a_n  = sh0;
                b_n  = sh1;
                c_n  = sh2;
                d_n  = bus.din;
                fv_n = 1'b1;
              end
            endcase
          end
        end
        default: state_n = S_HUNT;
      endcase
    end
  end

  assign bus.a           = a_r;
  assign bus.b           = b_r;
  assign bus.c           = c_r;
  assign bus.d           = d_r;
  assign bus.s           = slot;
  assign bus.locked      = (state == S_LOCKED);
  assign bus.frame_valid = fv_r;
  assign bus.sync_err    = se_r;
endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - directed and randomized bench for tdm_demux4 against a frame-queue model
module tb_tdm_demux4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdm_demux4_if #(.WIDTH(W)) bus ();
  tdm_demux4 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  // Model: the partial frame is just the list of beats accepted since the last slot 0.
  logic [W-1:0] m_out [4];
  logic [W-1:0] m_q [$];
  logic         m_locked;
  logic         m_fv;
  logic         m_se;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic sy, input logic [W-1:0] dat);
    if (r) begin
      for (int i = 0; i < 4; i++) m_out[i] = '0;
      m_q.delete();
      m_locked = 1'b0;
      m_fv = 1'b0;
      m_se = 1'b0;
    end else begin
      m_fv = 1'b0;
      m_se = 1'b0;
      if (v) begin
        if (!m_locked) begin
          if (sy) begin
            m_locked = 1'b1;
            m_q.delete();
            m_q.push_back(dat);
          end
        end else if (sy && m_q.size() != 0) begin
          m_se = 1'b1;
          m_q.delete();
          m_q.push_back(dat);
        end else begin
          m_q.push_back(dat);
          if (m_q.size() == 4) begin
            for (int i = 0; i < 4; i++) m_out[i] = m_q[i];
            m_fv = 1'b1;
            m_q.delete();
          end
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic sy, input logic [W-1:0] dat);
    rst        = r;
    bus.dvalid = v;
    bus.sync   = sy;
    bus.din    = dat;
    @(posedge clk);
    model_edge(r, v, sy, dat);
    #1;
    check("a", 32'(bus.a), 32'(m_out[0]));
    check("b", 32'(bus.b), 32'(m_out[1]));
    check("c", 32'(bus.c), 32'(m_out[2]));
    check("d", 32'(bus.d), 32'(m_out[3]));
    check("s", 32'(bus.s), 32'(m_q.size()));
    check("locked", 32'(bus.locked), 32'(m_locked));
    check("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
    check("sync_err", 32'(bus.sync_err), 32'(m_se));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), W'($urandom));
  endtask

  task automatic frame(input logic [4*W-1:0] beats, input logic sync0, input int gap);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, (k == 0) ? sync0 : 1'b0, beats[(3-k)*W +: W]);
      if (k != 3) idle(gap);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    rst        = 1'b1;
    bus.dvalid = 1'b0;
    bus.sync   = 1'b0;
    bus.din    = '0;
    for (int i = 0; i < 4; i++) m_out[i] = '0;
    m_locked = 1'b0;
    m_fv = 1'b0;
    m_se = 1'b0;

    do_reset(2);
    frame(16'hABCD, 1'b1, 0);
    idle(2);

    do_reset(1);
    step(1'b0, 1'b1, 1'b0, 4'b0111);
    step(1'b0, 1'b1, 1'b0, 4'b0110);
    frame(16'hABCD, 1'b1, 0);

    do_reset(1);
    frame(16'hABCD, 1'b1, 3);
    idle(3);

    do_reset(1);
    step(1'b0, 1'b1, 1'b1, 4'b1010);
    step(1'b0, 1'b1, 1'b0, 4'b1011);
    frame(16'h1234, 1'b1, 0);

    do_reset(1);
    frame(16'hABCD, 1'b1, 0);
    frame(16'h5432, 1'b0, 0);
    idle(2);

    do_reset(1);
    step(1'b0, 1'b1, 1'b1, 4'b1010);
    step(1'b0, 1'b1, 1'b0, 4'b1011);
    step(1'b1, 1'b1, 1'b0, 4'b1100);
    step(1'b0, 1'b1, 1'b0, 4'b1101);
    step(1'b0, 1'b1, 1'b0, 4'b1110);
    idle(1);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 5) == 0),
           W'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Time-division 1-to-4 demultiplexer; the receive-side counterpart to the team's 4:1 channel mux.
- Accepts a serial stream of WIDTH-bit beats on one bus, distributes consecutive beats to four channel registers A, B, C, D, and publishes each complete frame in parallel with a one-cycle strobe.
- Frame alignment comes from a SYNC marker on the slot-0 beat.

Parameters:
- WIDTH, 4, bit width of each beat and of each channel output.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- DIN  input  WIDTH  incoming beat.
- DVALID  input  1  DIN carries a beat this cycle.
- SYNC  input  1  marks the current beat as slot 0 (channel A); only meaningful when DVALID=1.
- A  output  WIDTH  channel 0 of the last complete frame.
- B  output  WIDTH  channel 1 of the last complete frame.
- C  output  WIDTH  channel 2 of the last complete frame.
- D  output  WIDTH  channel 3 of the last complete frame.
- S  output  2  slot index expected for the next beat.
- LOCKED  output  1  frame alignment acquired.
- FRAME_VALID  output  1  one-cycle pulse: A–D just updated.
- SYNC_ERR  output  1  one-cycle pulse: SYNC arrived mid-frame.

Behaviour:
- Reset (RST=1 at an edge): A=B=C=D=0, S=0, LOCKED=0, FRAME_VALID=0, SYNC_ERR=0, shadow registers=0, state=HUNT. RST has priority over all other inputs. Reset mid-frame discards the partial frame.
- Cycles with DVALID=0 change nothing except clearing FRAME_VALID and SYNC_ERR. SYNC is ignored when DVALID=0.
- State HUNT:
  - Beats with SYNC=0 are dropped; S stays 0.
  - A beat with SYNC=1 is stored in shadow slot 0; S becomes 1 and the state moves to LOCKED. LOCKED=1 from the following cycle.
- State LOCKED, beat with SYNC=0:
  - The beat is stored in shadow[S]; S increments and wraps 3 -> 0.
  - When the accepted beat is slot 3, A, B, C, D are loaded from shadow[0..2] and the current DIN on that same edge.
  - FRAME_VALID=1 for exactly the next cycle.
  - Latency: slot-3 beat accepted at edge N -> A–D valid and FRAME_VALID=1 after edge N.
- State LOCKED, beat with SYNC=1 and S=0: normal slot-0 beat.
- State LOCKED, beat with SYNC=1 and S≠0 (misalignment):
  - The partial frame is discarded; A–D hold their previous values.
  - SYNC_ERR=1 for one cycle.
  - The beat is stored as slot 0 and S becomes 1; the state stays LOCKED.
- A slot-0 beat with SYNC=0 in LOCKED is accepted (SYNC is not required every frame).
- A–D hold their values indefinitely between frames; they never show a partial frame.
- FRAME_VALID and SYNC_ERR are never both 1 in the same cycle.
- Back-to-back frames at full rate (DVALID=1 every cycle) are sustained: FRAME_VALID pulses every 4th cycle.
- No arithmetic beyond the 2-bit wrapping slot counter. Data passes through unmodified, WIDTH bits wide.

Test Plan:
- Reset then basic frame: RST for 2 cycles; then 4 consecutive beats 1010(SYNC=1), 1011, 1100, 1101 -> after 4th edge A=1010, B=1011, C=1100, D=1101, FRAME_VALID=1 for 1 cycle, S=0, LOCKED=1.
- HUNT discard: beats 0111, 0110 with SYNC=0, then the frame above -> 0111/0110 never appear on A–D; outputs as above; LOCKED=0 until after the SYNC beat.
- Gapped input: same frame with DVALID=0 for 3 cycles between every beat -> identical A–D, single FRAME_VALID pulse, S holds during gaps.
- Misaligned SYNC: beats 1010(SYNC), 1011, then 0001(SYNC), 0010, 0011, 0100 -> SYNC_ERR pulse on the 0001 beat, A–D unchanged (0 after reset), then A=0001, B=0010, C=0011, D=0100 with FRAME_VALID.
- Full-rate streaming: two frames (1010, 1011, 1100, 1101) then (0101, 0100, 0011, 0010) back to back -> FRAME_VALID at cycles 4 and 8; second frame on A–D after cycle 8.
- Reset mid-frame: after 1010(SYNC), 1011, assert RST for 1 cycle -> all outputs 0, LOCKED=0, S=0; subsequent beats without SYNC are ignored.
